// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters. It accepts one operation
// at a time, holds the ALU operands for ALU_LAT edges, and returns the result
// on the owner's response port with backpressure.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking;
// otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_alucode,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_alucode,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [5:0]  alu_code,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  input  logic [31:0] alu_result,
  output logic        busy
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             capture;
  logic             done;

`ifdef ALU_ARB_RR_EN
  logic             last_q;

  // Round-robin: on a tie grant the port that did not win last time.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
  end

  // Last-grant pointer; reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant1;
    end
  end
`else
  // Fixed priority: port 0 always wins.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        done = owner_q ? rsp1_ready : rsp0_ready;
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive registers, latency counter and owner; loaded only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_code <= '0;
      alu_r1   <= '0;
      alu_r2   <= '0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      alu_code <= grant1 ? req1_alucode : req0_alucode;
      alu_r1   <= grant1 ? req1_op1 : req0_op1;
      alu_r2   <= grant1 ? req1_op2 : req0_op2;
      owner_q  <= grant1;
      cnt_q    <= '0;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response registers: set on capture, cleared on the owner's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
    end else if (capture) begin
      if (owner_q) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
      end else begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
      end
    end else if (done) begin
      if (owner_q) begin
        rsp1_valid <= 1'b0;
      end else begin
        rsp0_valid <= 1'b0;
      end
    end
  end

  // Registered busy flag tracking the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed test-plan steps followed by random
// operations, checked against a behavioural model of arbitration and ALU math.
module tb_alu_arbiter;

  localparam int unsigned LAT = 1;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd5;
  localparam logic [5:0] OP_SRL = 6'd6;
  localparam logic [5:0] OP_SRA = 6'd7;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_alucode, req1_alucode;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [5:0]  alu_code;
  logic [31:0] alu_r1, alu_r2, alu_result;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int last_grant = 1;

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alucode(req0_alucode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alucode(req1_alucode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_code(alu_code), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_result(alu_result),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU arithmetic.
  function automatic logic [31:0] alu_ref(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // ALU stand-in with LAT registered stages.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_ref(alu_code, alu_r1, alu_r2);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_result = pipe[LAT-1];

  // Which port should win given the current valids.
  function automatic int pred_grant(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return (last_grant == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
    chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
    chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
    chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
    chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
    chk({tag, "_alu_code"}, 32'(alu_code), 32'd0);
    chk({tag, "_alu_r1"}, alu_r1, 32'd0);
    chk({tag, "_alu_r2"}, alu_r2, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One complete operation from IDLE back to IDLE; payloads set by caller.
  task automatic run_op(input logic v0, input logic v1, input int stall,
                        output int gp, output logic [31:0] res);
    logic [31:0] exp;
    logic        own_v, oth_v;
    req0_valid = v0;
    req1_valid = v1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    gp  = pred_grant(v0, v1);
    exp = (gp == 0) ? alu_ref(req0_alucode, req0_op1, req0_op2)
                    : alu_ref(req1_alucode, req1_op1, req1_op2);
    if (stall == 0) begin
      if (gp == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    end
    #2;
    chk("idle_req0_ready", 32'(req0_ready), 32'(gp == 0));
    chk("idle_req1_ready", 32'(req1_ready), 32'(gp == 1));
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    last_grant = gp;
    if (gp == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    for (int k = 0; k <= int'(LAT); k++) begin
      chk("exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("exec_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_req0_ready", 32'(req0_ready), 32'd0);
      chk("exec_req1_ready", 32'(req1_ready), 32'd0);
      tick();
    end
    own_v = (gp == 0) ? rsp0_valid : rsp1_valid;
    oth_v = (gp == 0) ? rsp1_valid : rsp0_valid;
    res   = (gp == 0) ? rsp0_result : rsp1_result;
    chk("rsp_valid", 32'(own_v), 32'd1);
    chk("rsp_other_valid", 32'(oth_v), 32'd0);
    chk("rsp_result", res, exp);
    chk("rsp_busy", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      if (gp == 0) rsp1_ready = 1'($urandom); else rsp0_ready = 1'($urandom);
      tick();
      own_v = (gp == 0) ? rsp0_valid : rsp1_valid;
      oth_v = (gp == 0) ? rsp1_valid : rsp0_valid;
      chk("hold_valid", 32'(own_v), 32'd1);
      chk("hold_other_valid", 32'(oth_v), 32'd0);
      chk("hold_result", (gp == 0) ? rsp0_result : rsp1_result, exp);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    if (gp == 0) begin rsp0_ready = 1'b1; rsp1_ready = 1'b0; end
    else begin rsp1_ready = 1'b1; rsp0_ready = 1'b0; end
    tick();
    chk("done_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("done_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic set_req(input int port, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    if (port == 0) begin
      req0_alucode = c; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_alucode = c; req1_op1 = a; req1_op2 = b;
    end
  endtask

  initial begin
    int          gp;
    logic [31:0] res;
    logic        v0, v1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(0, 6'd0, 32'd0, 32'd0);
    set_req(1, 6'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Single ADD on port 0.
    set_req(0, OP_ADD, 32'd34, 32'd55);
    run_op(1'b1, 1'b0, 0, gp, res);
    chk("add_port", 32'(gp), 32'd0);
    chk("add_result", res, 32'd89);

    // Single SUB on port 1.
    set_req(1, OP_SUB, 32'd55, 32'd56);
    run_op(1'b0, 1'b1, 0, gp, res);
    chk("sub_port", 32'(gp), 32'd1);
    chk("sub_result", res, 32'hFFFF_FFFF);

    // Tie: port 0 first, then the waiting port 1.
    set_req(0, OP_XOR, 32'hBADC_AB1E, 32'hFEED_FACE);
    set_req(1, OP_AND, 32'hBADC_AB1E, 32'hFEED_FACE);
    run_op(1'b1, 1'b1, 0, gp, res);
    chk("tie_first_port", 32'(gp), 32'd0);
    chk("tie_first_result", res, 32'h4431_51D0);
    run_op(1'b0, 1'b1, 0, gp, res);
    chk("tie_second_port", 32'(gp), 32'd1);
    chk("tie_second_result", res, 32'hBACC_AA0E);

    // Continuous contention.
    set_req(0, OP_OR, 32'hBADC_AB1E, 32'hFEED_FACE);
    set_req(1, OP_OR, 32'hBADC_AB1E, 32'hFEED_FACE);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b1, 0, gp, res);
`ifdef ALU_ARB_RR_EN
      chk("contend_port", 32'(gp), 32'(i % 2));
`else
      chk("contend_port", 32'(gp), 32'd0);
`endif
      chk("contend_result", res, 32'hFEFD_FBDE);
    end

    // Backpressure for 5 cycles.
    set_req(0, OP_SRA, 32'hDEAD_DEAD, 32'd16);
    run_op(1'b1, 1'b0, 5, gp, res);
    chk("sra_result", res, 32'hFFFF_DEAD);

    // Reset during EXEC of a port 1 SLL.
    set_req(1, OP_SLL, 32'hFEED_FACE, 32'd1036);
    req1_valid = 1'b1;
    #2;
    chk("rst_accept_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("rst_in_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    tick();
    rst_n = 1'b1;
    last_grant = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    set_req(0, OP_ADD, 32'd1000, 32'd2345);
    run_op(1'b1, 1'b0, 0, gp, res);
    chk("post_rst_result", res, 32'd3345);
    set_req(0, OP_SUB, 32'd7, 32'd9);
    set_req(1, OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    run_op(1'b1, 1'b1, 1, gp, res);
    chk("post_rst_tie_port", 32'(gp), 32'd0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      set_req(0, 6'($urandom_range(0, 7)), $urandom, $urandom);
      set_req(1, 6'($urandom_range(0, 7)), $urandom, $urandom);
      run_op(v0, v1, int'($urandom_range(0, 3)), gp, res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single `alu` instance between two requesters, e.g. the integer pipe and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake and holds the operands stable on the ALU ports for the ALU's registered latency. It captures the result and returns it on the requester's own response port with backpressure. The ALU's `using_r2` is tied `TRUE` and `using_pc` is tied `FALSE` outside this block.

## Interface

Parameters:
- `ALU_LAT`, 1: clock edges from stable ALU inputs to a valid `alu_result`. Range 1–4.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_alucode` / `req1_alucode` in 6: ALU operation code.
- `req0_op1` / `req1_op1` in 32: first operand.
- `req0_op2` / `req1_op2` in 32: second operand.
- `rsp0_valid` / `rsp1_valid` out 1: result available.
- `rsp0_ready` / `rsp1_ready` in 1: requester takes the result.
- `rsp0_result` / `rsp1_result` out 32: result value.
- `alu_code` out 6: drives `alu.alucode`.
- `alu_r1` out 32: drives `alu.r1`.
- `alu_r2` out 32: drives `alu.r2`.
- `alu_result` in 32: from `alu.alu_result`.
- `busy` out 1: high in any state other than IDLE.

## Operation

- **IDLE**
  - Grant logic chooses among the asserted `reqN_valid` lines.
  - `reqN_ready` = IDLE & grantN, so at most one ready is high and it is never high without its valid.
  - On accept, latch alucode/op1/op2 into `alu_code`/`alu_r1`/`alu_r2`, record the owner, clear the counter, and go to EXEC.
- **EXEC**
  - ALU drive registers are held constant.
  - The counter increments each edge.
  - On the edge where the counter equals `ALU_LAT`:
    - capture `alu_result` into `rspOWNER_result`;
    - set `rspOWNER_valid`;
    - go to RESP.
- **RESP**
  - `rspOWNER_valid` and `rspOWNER_result` are held until `rspOWNER_ready` is high.
  - On that handshake edge: clear valid and go to IDLE.
  - The non-owner rsp_valid stays 0.
- **Payload rules**
  - The requester must hold its payload stable while valid and not ready.
  - The arbiter never re-samples the payload after accept.
- **Codes and arithmetic**
  - alucode is passed through unmodified; undefined codes are not checked.
  - The result is taken verbatim; no width change or sign handling here.
- **Simultaneous events**
  - `rspN_ready` asserted while not valid is ignored.
  - A request arriving during EXEC/RESP waits and is served in the next IDLE.
- **Reset mid-operation**
  - Any in-flight op is discarded and no response is produced.
  - Grant pointer returns to its reset value.

## Timing

- Reset values:
  - `req*_ready`, `rsp*_valid`, `busy`: 0.
  - `rsp*_result`, `alu_code`, `alu_r1`, `alu_r2`: 0.
  - State: IDLE.
  - Last-grant pointer: 1, so port 0 wins the first tie.
- Accept on edge E0 → ALU inputs valid from E0 → `rsp_valid` high after edge E0+ALU_LAT+1.
  - With `ALU_LAT`=1: the result is visible 2 cycles after accept.
- Response handshake on edge E → IDLE after E; the next accept is at E+1 at the earliest.
- Best-case throughput: one operation per ALU_LAT+3 cycles.
- `busy` is registered and equals (state != IDLE).

## Configuration

- Macro: `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - On a tie, grant the port not recorded in the last-grant pointer.
  - The pointer updates on every accept.
- Undefined: fixed priority; port 0 always wins ties.
  - The pointer is not implemented.
  - A port 1 request is served only in an IDLE cycle with `req0_valid`=0.

## Test plan

1. **Single ADD.** Port 0 `ADD` 34, 55 with `rsp0_ready`=1.
   - `rsp0_result`=89 two cycles after accept.
   - `rsp1_valid` stays 0.
   - `busy` is high for exactly 3 cycles.
2. **Single SUB on port 1.** Port 1 `SUB` 55, 56.
   - `rsp1_result`=0xFFFFFFFF.
   - `req0_ready` stays 0 throughout.
3. **Tie.** Both valid in the same cycle: port 0 `XOR` 0xBADCAB1E, 0xFEEDFACE; port 1 `AND` with the same operands.
   - Port 0 is served first with 0x443151D0, then port 1 with 0xBACCAA0E.
4. **Continuous contention.** Both ports continuously valid with `OR` 0xBADCAB1E, 0xFEEDFACE.
   - With `ALU_ARB_RR_EN`: grants alternate 0,1,0,1 and every result is 0xFEFDFBDE.
   - Without it: port 0 is granted every time and port 1 is never granted.
5. **Backpressure.** Port 0 `SRA` 0xDEADDEAD, 16 with `rsp0_ready`=0 for 5 cycles.
   - `rsp0_valid`=1 and `rsp0_result`=0xFFFFDEAD are held.
   - `req*_ready` stays 0 and `busy`=1.
   - Releasing `rsp0_ready` returns to IDLE the next cycle.
6. **Reset mid-EXEC.** Assert `rst_n`=0 during EXEC of a port 1 `SLL` 0xFEEDFACE, 1036.
   - All outputs are immediately at their reset values.
   - No `rsp1_valid` appears after `rst_n` is released.
   - A fresh port 0 request is then served normally.
